// File: rtl/code_step_ctrl.sv
// code_step_ctrl
//   Pushbutton front end for the inverse code decoder. Two raw buttons (up,
//   down) are synchronised, debounced and edge-detected; every press steps a
//   4-bit code register held in 0..MAX_CODE. Optional auto-repeat keeps
//   stepping while a button is held.
//
//   Build option: define CODE_STEP_WRAP_EN to make the code wrap around
//   (MAX_CODE+1 -> 0, 0-1 -> MAX_CODE) instead of saturating.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   btn_up_i   in   raw up button (asynchronous, active-high)
//   btn_dn_i   in   raw down button (asynchronous, active-high)
//   code_o     out  current code, 0..MAX_CODE
//   code_chg_o out  one-cycle pulse in the cycle code_o takes a new value
//   at_min_o   out  code_o == 0
//   at_max_o   out  code_o == MAX_CODE
//
// Index 0 of every per-button vector/array is the up button, index 1 is down.
module code_step_ctrl #(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 0,
  parameter int MAX_CODE      = 4,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [3:0] code_o,
  output logic       code_chg_o,
  output logic       at_min_o,
  output logic       at_max_o
);

  // The stable level flips on the cycle the counter would reach DEB_CYCLES,
  // so the comparison is against DEB_CYCLES-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam bit               RPT_EN   = (REPEAT_CYCLES > 0);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [3:0]       MAX_VAL  = 4'(MAX_CODE);

  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic [CNT_W-1:0] rpt_cnt_d [2];
  logic [1:0]       press;
  logic [1:0]       step;
  logic [3:0]       code_q, code_d;
  logic             chg_q, chg_d;

  assign raw   = {btn_dn_i, btn_up_i};
  assign press = stable_q & ~stable_dly_q;

  // Synchroniser, debounce, edge detect and auto-repeat for both buttons.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    step         = press;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      rpt_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
      // Repeat counter runs only while held and not on the press cycle
      // itself, so repeats land REPEAT_CYCLES apart starting at the press.
      if (RPT_EN && stable_q[i] && !press[i]) begin
        if (rpt_cnt_q[i] == RPT_LAST) begin
          step[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Code register update. Simultaneous up and down steps cancel.
  always_comb begin
    code_d = code_q;
    chg_d  = 1'b0;
    if (step[0] && !step[1]) begin
      if (code_q < MAX_VAL) begin
        code_d = code_q + 4'd1;
        chg_d  = 1'b1;
      end
`ifdef CODE_STEP_WRAP_EN
      else begin
        code_d = 4'd0;
        chg_d  = 1'b1;
      end
`endif
    end else if (step[1] && !step[0]) begin
      if (code_q > 4'd0) begin
        code_d = code_q - 4'd1;
        chg_d  = 1'b1;
      end
`ifdef CODE_STEP_WRAP_EN
      else begin
        code_d = MAX_VAL;
        chg_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
        rpt_cnt_q[i] <= '0;
      end
      code_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
      code_q <= code_d;
      chg_q  <= chg_d;
    end
  end

  assign code_o     = code_q;
  assign code_chg_o = chg_q;
  assign at_min_o   = (code_q == 4'd0);
  assign at_max_o   = (code_q == MAX_VAL);

endmodule

// File: tb/tb_code_step_ctrl.sv
// Directed bench for code_step_ctrl. Instance a: DEB_CYCLES=4, no repeat.
// Instance b: DEB_CYCLES=4, REPEAT_CYCLES=10. Inputs are driven and outputs
// sampled 1 ns after each rising edge; edge n is the n-th rising edge after
// a stimulus change.
module tb_code_step_ctrl;

  logic       clk;
  logic       reset;
  logic       up_a, dn_a, up_b, dn_b;
  logic [3:0] code_a, code_b;
  logic       chg_a, chg_b, min_a, min_b, max_a, max_b;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int exp_code;
  int pulse_edge [4];
  int n_pulse;

  code_step_ctrl #(.DEB_CYCLES(4), .REPEAT_CYCLES(0), .MAX_CODE(4), .CNT_W(20)) dut_a (
    .clk(clk), .reset(reset), .btn_up_i(up_a), .btn_dn_i(dn_a),
    .code_o(code_a), .code_chg_o(chg_a), .at_min_o(min_a), .at_max_o(max_a)
  );

  code_step_ctrl #(.DEB_CYCLES(4), .REPEAT_CYCLES(10), .MAX_CODE(4), .CNT_W(20)) dut_b (
    .clk(clk), .reset(reset), .btn_up_i(up_b), .btn_dn_i(dn_b),
    .code_o(code_b), .code_chg_o(chg_b), .at_min_o(min_b), .at_max_o(max_b)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; counts code_chg pulses seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (chg_a) pulses_a++;
    if (chg_b) pulses_b++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    tick();
  endtask

  // Clean press on instance a: 10 cycles held, 10 released.
  task automatic press_a(input logic up, input logic dn);
    up_a = up;
    dn_a = dn;
    ticks(10);
    up_a = 1'b0;
    dn_a = 1'b0;
    ticks(10);
  endtask

  function automatic int model_up(input int c);
`ifdef CODE_STEP_WRAP_EN
    return (c == 4) ? 0 : c + 1;
`else
    return (c == 4) ? 4 : c + 1;
`endif
  endfunction

  function automatic int model_dn(input int c);
`ifdef CODE_STEP_WRAP_EN
    return (c == 0) ? 4 : c - 1;
`else
    return (c == 0) ? 0 : c - 1;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    up_a = 1'b0; dn_a = 1'b0; up_b = 1'b0; dn_b = 1'b0;

    // 1: reset values
    do_reset();
    chk("rst_code", code_a, 0);
    chk("rst_min", min_a, 1);
    chk("rst_max", max_a, 0);
    chk("rst_chg", chg_a, 0);
    chk("rst_code_b", code_b, 0);

    // 2: single held press, code changes exactly at edge 7
    pulses_a = 0;
    up_a = 1'b1;
    ticks(6);
    chk("lat_before", code_a, 0);
    tick();
    chk("lat_code", code_a, 1);
    chk("lat_chg", chg_a, 1);
    tick();
    chk("lat_chg_drop", chg_a, 0);
    ticks(12);
    up_a = 1'b0;
    ticks(15);
    chk("hold_pulses", pulses_a, 1);
    chk("hold_code", code_a, 1);
    chk("hold_min", min_a, 0);

    // 3: bounce then stable high gives one step
    do_reset();
    pulses_a = 0;
    up_a = 1'b1; ticks(2);
    up_a = 1'b0; ticks(2);
    up_a = 1'b1; ticks(2);
    up_a = 1'b0; ticks(2);
    chk("bounce_none", pulses_a, 0);
    up_a = 1'b1; ticks(15);
    up_a = 1'b0; ticks(15);
    chk("bounce_pulses", pulses_a, 1);
    chk("bounce_code", code_a, 1);

    // 4: six up presses, saturation at MAX_CODE
    do_reset();
    exp_code = 0;
    for (int i = 1; i <= 6; i++) begin
      int prev;
      prev = exp_code;
      exp_code = model_up(exp_code);
      pulses_a = 0;
      press_a(1'b1, 1'b0);
      chk($sformatf("up%0d_code", i), code_a, exp_code);
      chk($sformatf("up%0d_pulses", i), pulses_a, (exp_code != prev) ? 1 : 0);
      chk($sformatf("up%0d_max", i), max_a, (exp_code == 4) ? 1 : 0);
    end

    // 5: simultaneous up+down cancels; down to 0 and past it
    do_reset();
    press_a(1'b1, 1'b0);
    press_a(1'b1, 1'b0);
    chk("two_code", code_a, 2);
    pulses_a = 0;
    press_a(1'b1, 1'b1);
    chk("both_code", code_a, 2);
    chk("both_pulses", pulses_a, 0);
    exp_code = 2;
    for (int i = 1; i <= 3; i++) begin
      int prev;
      prev = exp_code;
      exp_code = model_dn(exp_code);
      pulses_a = 0;
      press_a(1'b0, 1'b1);
      chk($sformatf("dn%0d_code", i), code_a, exp_code);
      chk($sformatf("dn%0d_pulses", i), pulses_a, (exp_code != prev) ? 1 : 0);
      chk($sformatf("dn%0d_min", i), min_a, (exp_code == 0) ? 1 : 0);
    end

    // 6: auto-repeat, steps at edges 7, 17, 27, 37
    do_reset();
    n_pulse = 0;
    for (int k = 0; k < 4; k++) pulse_edge[k] = 0;
    up_b = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (chg_b) begin
        if (n_pulse < 4) pulse_edge[n_pulse] = e;
        n_pulse++;
      end
    end
    up_b = 1'b0;
    pulses_b = 0;
    ticks(15);
    chk("rpt_count", n_pulse, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rpt_edge%0d", k), pulse_edge[k], 7 + 10 * k);
    chk("rpt_after", pulses_b, 0);
    chk("rpt_code", code_b, 4);
    chk("rpt_max", max_b, 1);

    // 6b: reset in the middle of a held press
    do_reset();
    up_b = 1'b1;
    ticks(24);
    chk("mid_code", code_b, 2);
    reset = 1'b1;
    tick();
    chk("mid_rst_code", code_b, 0);
    chk("mid_rst_min", min_b, 1);
    reset = 1'b0;
    pulses_b = 0;
    ticks(6);
    chk("mid_no_step", pulses_b, 0);
    chk("mid_wait_code", code_b, 0);
    tick();
    chk("mid_step_code", code_b, 1);
    chk("mid_step_chg", chg_b, 1);
    up_b = 1'b0;
    ticks(15);
    chk("mid_final", code_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/code_step_ctrl.md
Name: code_step_ctrl

Overview:
- Pushbutton front end that produces the 4-bit code (range 0..MAX_CODE) consumed by the downstream inverse code decoder.
- Synchronises and debounces two raw buttons (up, down) and edge-detects presses.
- Optionally auto-repeats while a button is held.
- Maintains a saturating code register and flags every change.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a new button level (>=1).
- REPEAT_CYCLES, 0, hold time between auto-repeat steps; 0 disables auto-repeat.
- MAX_CODE, 4, highest legal code value (<=15).
- CNT_W, 20, width of the debounce and repeat counters; must hold max(DEB_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_up_i  input  1  raw up button, asynchronous, active-high.
- btn_dn_i  input  1  raw down button, asynchronous, active-high.
- code_o  output  4  current code, 0..MAX_CODE; feeds the decoder's code input.
- code_chg_o  output  1  one-cycle pulse in the cycle code_o takes a new value.
- at_min_o  output  1  high while code_o == 0.
- at_max_o  output  1  high while code_o == MAX_CODE.

Behaviour:
- Reset values: code_o=0, code_chg_o=0, at_min_o=1, at_max_o=0.
- Reset also clears all synchroniser flops, debounce stable states, debounce counters, edge-delay flops and repeat counters.
- Reset asserted mid-press: after release of reset the button must go through a full debounce before any step is generated.
- Synchroniser: 2 flip-flops per button.
- Debounce, per button:
  - Counter increments each cycle the synced level differs from the stable level.
  - Counter clears on any cycle where they match.
  - When the counter reaches DEB_CYCLES, the stable level flips and the counter clears.
- Press step: stable 0->1 transition (stable & ~stable_d) gives a one-cycle step. Release generates nothing.
- Auto-repeat, only when REPEAT_CYCLES>0:
  - While the stable level is 1, the repeat counter counts.
  - Each time it reaches REPEAT_CYCLES: one additional step, counter clears.
  - Counter clears when the stable level is 0 and on a press step.
- Latency: raw input high and steady from before edge 1 -> code_o updates at edge DEB_CYCLES+3. code_chg_o is high in the same cycle.
- Code update, registered:
  - Up step only, code_o < MAX_CODE: code_o+1.
  - Down step only, code_o > 0: code_o-1.
  - Up and down steps in the same cycle: no change, no code_chg_o.
  - Up at MAX_CODE or down at 0: saturate, no change, no code_chg_o (default build).
- code_chg_o is registered alongside code_o and is never high two consecutive cycles unless two steps occur on consecutive cycles.
- at_min_o and at_max_o are decoded from the registered code_o, so they reflect the current output value with zero extra latency.
- Arithmetic is 4-bit unsigned; code_o never exceeds MAX_CODE.

Optional Feature:
- Macro: CODE_STEP_WRAP_EN.
- Defined: up at MAX_CODE goes to 0, and down at 0 goes to MAX_CODE. Both wraps pulse code_chg_o.
- Defined: simultaneous up and down steps still produce no change.
- Not defined: saturation as described in Behaviour. No wrap logic is synthesised.

Test Plan:
- Reset held 3 cycles then released, buttons low -> code_o=0, at_min_o=1, at_max_o=0, code_chg_o=0.
- DEB_CYCLES=4, up held 20 cycles -> code_o 0->1 exactly at edge 7 after press, one code_chg_o pulse, no further change on release.
- Up bounce 1,0,1,0 every 2 cycles then stable high (DEB_CYCLES=4) -> only one step; code_o=1; code_chg_o pulses once.
- Five clean up presses then one more -> code_o reaches 4 with at_max_o=1; sixth press leaves 4, no code_chg_o.
  - With CODE_STEP_WRAP_EN defined, the sixth press gives 0 with a code_chg_o pulse.
- code_o=2, up and down raw edges applied in the same cycle -> both step in the same cycle, code_o stays 2, no code_chg_o.
- REPEAT_CYCLES=10, DEB_CYCLES=4, code_o=0, down held... (replace) code_o=0, up held 40 cycles -> steps at press +0, +10, +20, +30 after debounce; code_o saturates at 4 and code_chg_o pulses 4 times.
  - Reset asserted at cycle 25 of the hold returns code_o to 0; no step until the button debounces again after reset release.
